// File: rtl/ixc_assign_sched_pkg.sv
// Shared types and default constants for the assign scheduler.
package ixc_assign_sched_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 6;
  localparam int unsigned HOLD_DEF = 2;

  // Settle counter width; covers HOLD_CYC up to 15
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/ixc_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at NREQ.
module ixc_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   sel
);

  logic [PW-1:0] idx;

  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/ixc_assign_sched.sv
// Shared-value assign scheduler: round-robin grant, one-cycle write, optional settle hold.
module ixc_assign_sched
  import ixc_assign_sched_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned HOLD_CYC = HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     freeze,
  output logic [W-1:0]             L,
  output logic                     upd,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);

  localparam int unsigned PW = $clog2(NREQ);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     sel;
  logic              any;
  logic              hs;
  logic [W-1:0]      data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign data_arr[g] = req_data[g*W +: W];
  end

  ixc_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .any  (any),
    .sel  (sel)
  );

  // A grant is only offered in IDLE, unfrozen, out of reset
  assign hs        = (state == IDLE) && !freeze && !rst && any;
  assign req_ready = hs ? (NREQ'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (hs && (HOLD_CYC > 0)) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Shared value, grant id, pointer and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      L      <= '0;
      upd    <= 1'b0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else begin
      upd  <= hs;
      busy <= (state_nxt == SETTLE);
      if (hs) begin
        L      <= data_arr[sel];
        gnt_id <= sel;
        ptr    <= (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ixc_assign_sched.sv
// Table-driven bench with grant scoreboard for ixc_assign_sched (HOLD 2 and HOLD 0 instances).
module tb_ixc_assign_sched;

  localparam logic [23:0] DATA = {6'h3F, 6'h2A, 6'h15, 6'h07};
  localparam logic [23:0] D2   = {6'h01, 6'h02, 6'h33, 6'h04};

  typedef struct {
    logic        rst;
    logic        frz;
    logic [3:0]  rv;
    logic [23:0] data;
    logic [3:0]  rdy;
    logic [5:0]  l;
    logic        upd;
    logic [1:0]  gnt;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [5:0] l;
    logic [1:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [3:0]  req_valid, req_ready;
  logic [23:0] req_data;
  logic [5:0]  l_out;
  logic        upd, busy;
  logic [1:0]  gnt_id;

  logic        z_rst, z_freeze;
  logic [3:0]  z_valid, z_ready;
  logic [23:0] z_data;
  logic [5:0]  z_l;
  logic        z_upd, z_busy;
  logic [1:0]  z_gnt;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  ixc_assign_sched #(.NREQ(4), .W(6), .HOLD_CYC(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .freeze(freeze), .L(l_out), .upd(upd),
    .gnt_id(gnt_id), .busy(busy)
  );

  ixc_assign_sched #(.NREQ(4), .W(6), .HOLD_CYC(0)) dut_z (
    .clk(clk), .rst(z_rst), .req_valid(z_valid), .req_data(z_data),
    .req_ready(z_ready), .freeze(z_freeze), .L(z_l), .upd(z_upd),
    .gnt_id(z_gnt), .busy(z_busy)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic [3:0] rv,
                     input logic [23:0] d, input logic [3:0] rdy, input logic [5:0] l,
                     input logic u, input logic [1:0] g, input logic b);
    vec_t v;
    v.rst = r; v.frz = f; v.rv = rv; v.data = d; v.rdy = rdy;
    v.l = l; v.upd = u; v.gnt = g; v.busy = b;
    vecs.push_back(v);
  endtask

  function automatic logic [5:0] dsel(input logic [23:0] d, input int id);
    return 6'(d >> (6 * id));
  endfunction

  initial begin
    rst = 1'b1; freeze = 1'b0; req_valid = '0; req_data = DATA;
    z_rst = 1'b1; z_freeze = 1'b0; z_valid = '0; z_data = DATA;

    // Reset scenario: request during reset is ignored, then granted with a 2-cycle settle
    add(1, 0, 4'b0100, DATA, 4'b0000, 6'h00, 0, 0, 0);
    add(1, 0, 4'b0100, DATA, 4'b0000, 6'h00, 0, 0, 0);
    add(0, 0, 4'b0100, DATA, 4'b0100, 6'h2A, 1, 2, 1);
    add(0, 0, 4'b0100, DATA, 4'b0000, 6'h2A, 0, 2, 1);
    add(0, 0, 4'b0100, DATA, 4'b0000, 6'h2A, 0, 2, 0);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h2A, 0, 2, 0);
    // Fairness: all requesting, grants 0,1,2,3,0 three cycles apart
    add(1, 0, 4'b1111, DATA, 4'b0000, 6'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      int id;
      id = i % 4;
      add(0, 0, 4'b1111, DATA, 4'(1 << id), dsel(DATA, id), 1, 2'(id), 1);
      add(0, 0, 4'b1111, DATA, 4'b0000, dsel(DATA, id), 0, 2'(id), 1);
      add(0, 0, 4'b1111, DATA, 4'b0000, dsel(DATA, id), 0, 2'(id), 0);
    end
    // Wrap: move ptr to 3, then 1001 grants 3 then 0
    add(0, 0, 4'b0100, DATA, 4'b0100, 6'h2A, 1, 2, 1);
    add(0, 0, 4'b1001, DATA, 4'b0000, 6'h2A, 0, 2, 1);
    add(0, 0, 4'b1001, DATA, 4'b0000, 6'h2A, 0, 2, 0);
    add(0, 0, 4'b1001, DATA, 4'b1000, 6'h3F, 1, 3, 1);
    add(0, 0, 4'b1001, DATA, 4'b0000, 6'h3F, 0, 3, 1);
    add(0, 0, 4'b1001, DATA, 4'b0000, 6'h3F, 0, 3, 0);
    add(0, 0, 4'b1001, DATA, 4'b0001, 6'h07, 1, 0, 1);
    add(0, 0, 4'b1001, DATA, 4'b0000, 6'h07, 0, 0, 1);
    add(0, 0, 4'b1001, DATA, 4'b0000, 6'h07, 0, 0, 0);
    // ptr back at 1; only the selected requester's data is sampled
    add(0, 0, 4'b1111, D2,   4'b0010, 6'h33, 1, 1, 1);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h33, 0, 1, 1);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h33, 0, 1, 0);
    // Freeze in IDLE blocks, release grants in the same cycle
    add(0, 1, 4'b0010, DATA, 4'b0000, 6'h33, 0, 1, 0);
    add(0, 1, 4'b0010, DATA, 4'b0000, 6'h33, 0, 1, 0);
    add(0, 0, 4'b0010, DATA, 4'b0010, 6'h15, 1, 1, 1);
    // Reset in first SETTLE cycle aborts settle and clears state
    add(1, 0, 4'b0000, DATA, 4'b0000, 6'h00, 0, 0, 0);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h00, 0, 0, 0);
    add(0, 0, 4'b1111, DATA, 4'b0001, 6'h07, 1, 0, 1);
    // Freeze does not stall the settle counter
    add(0, 1, 4'b1111, DATA, 4'b0000, 6'h07, 0, 0, 1);
    add(0, 1, 4'b1111, DATA, 4'b0000, 6'h07, 0, 0, 0);
    add(0, 1, 4'b1111, DATA, 4'b0000, 6'h07, 0, 0, 0);
    add(0, 0, 4'b1111, DATA, 4'b0010, 6'h15, 1, 1, 1);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h15, 0, 1, 1);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h15, 0, 1, 0);
    // Requester 2 drops before its turn; ptr stays at 2 so 0 wins, ptr -> 1
    add(0, 1, 4'b0100, DATA, 4'b0000, 6'h15, 0, 1, 0);
    add(0, 0, 4'b0001, DATA, 4'b0001, 6'h07, 1, 0, 1);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h07, 0, 0, 1);
    add(0, 0, 4'b0000, DATA, 4'b0000, 6'h07, 0, 0, 0);
    add(0, 0, 4'b1110, DATA, 4'b0010, 6'h15, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      rst = v.rst; freeze = v.frz; req_valid = v.rv; req_data = v.data;
      #1;
      chk("req_ready", i, 32'(req_ready), 32'(v.rdy));
      if (v.rdy != 4'b0000) begin
        exp_t e;
        for (int k = 0; k < 4; k++)
          if (v.rdy[k]) begin
            e.id = 2'(k);
            e.l  = dsel(v.data, k);
          end
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("L", i, 32'(l_out), 32'(v.l));
      chk("upd", i, 32'(upd), 32'(v.upd));
      chk("gnt_id", i, 32'(gnt_id), 32'(v.gnt));
      chk("busy", i, 32'(busy), 32'(v.busy));
      if (upd === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_upd", i, 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_L", i, 32'(l_out), 32'(e.l));
          chk("sb_id", i, 32'(gnt_id), 32'(e.id));
        end
      end
    end
    chk("sb_leftover", 0, 32'(sb.size()), 32'(0));

    // Zero-hold: 0011 held gives grants 0,1,0,1 on consecutive cycles, never busy
    @(negedge clk);
    z_rst = 1'b0; z_valid = 4'b0011; z_data = DATA;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("z_ready", i, 32'(z_ready), 32'(1 << (i % 2)));
      @(posedge clk);
      #1;
      chk("z_upd", i, 32'(z_upd), 32'(1));
      chk("z_gnt", i, 32'(z_gnt), 32'(i % 2));
      chk("z_L", i, 32'(z_l), 32'(dsel(DATA, i % 2)));
      chk("z_busy", i, 32'(z_busy), 32'(0));
      @(negedge clk);
    end
    z_valid = 4'b0000;
    @(posedge clk);
    #1;
    chk("z_upd_idle", 4, 32'(z_upd), 32'(0));
    chk("z_L_hold", 4, 32'(z_l), 32'(6'h15));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
